// File: rtl/logic_reduce_pkg.sv
// Shared types and the bitwise base operation for the logic reduce unit.
// Used by reduce_tree and logic_reduce_unit.
package logic_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Per-bit base op; NAND folds as AND and is inverted only on the final result.
  function automatic logic base_op(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_reduce_if.sv
// Stream-in / result-out handshake bundle for logic_reduce_unit.
// out_parity exists only when LOGIC_REDUCE_PARITY_EN is defined.
interface logic_reduce_if
  import logic_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CNT_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  op_e                   in_op;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CNT_W-1:0]      out_count;
`ifdef LOGIC_REDUCE_PARITY_EN
  logic                  out_parity;
`endif

  modport master (
    output in_valid, in_data, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
`ifdef LOGIC_REDUCE_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, in_data, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
`ifdef LOGIC_REDUCE_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/logic_reduce_unit_reduce_tree.sv
// Combinational N_IN-operand bitwise reduction of one beat with the base op.
module reduce_tree
  import logic_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_IN  = 4
) (
  input  logic [N_IN*WIDTH-1:0] data,
  input  op_e                   op,
  output logic [WIDTH-1:0]      result
);

  always_comb begin
    result = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      result[b] = data[b];
      for (int k = 1; k < int'(N_IN); k++) begin
        result[b] = base_op(op, result[b], data[k*int'(WIDTH) + b]);
      end
    end
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Registered multi-beat logic reducer with a one-deep result register.
// Optional out_parity port under LOGIC_REDUCE_PARITY_EN.
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  logic_reduce_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             start;
  op_e              eff_op;
  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] final_res;
  logic [CNT_W-1:0] cnt_next;

  assign accept = bus.in_valid && in_ready;
  // A beat accepted outside ACCUM opens a new packet (from IDLE or HOLD).
  assign start  = accept && (state_q != ACCUM);
  assign eff_op = start ? bus.in_op : op_q;

  reduce_tree #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_reduce_tree (
    .data   (bus.in_data),
    .op     (eff_op),
    .result (beat)
  );

  always_comb begin
    fold = beat;
    if (!start) begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        fold[b] = base_op(op_q, acc_q[b], beat[b]);
      end
    end
    final_res = (eff_op == OP_NAND) ? ~fold : fold;
  end

  always_comb begin
    if (start) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in HOLD a beat is only accepted when out_ready is high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = bus.in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (accept) begin
          state_d = bus.in_last ? HOLD : ACCUM;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q != HOLD) || bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else if (accept) begin
      op_q  <= eff_op;
      acc_q <= fold;
      cnt_q <= cnt_next;
      if (bus.in_last) begin
        out_data_q  <= final_res;
        out_count_q <= cnt_next;
      end
    end
  end

`ifdef LOGIC_REDUCE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (accept && bus.in_last) begin
      parity_q <= ^final_res;
    end
  end

  assign bus.out_parity = parity_q;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: doc/logic_reduce_unit.md
# logic_reduce_unit

Parametrised, registered successor to the team's 4-input AND cell. Reduces `N_IN` operands of `WIDTH` bits per beat with a runtime-selectable bitwise operation (AND/OR/XOR/NAND). Folds the results of consecutive beats into a running accumulator until a `last` beat. Presents the packet result on a valid/ready output with a one-deep output register. Sits between a stream source and downstream consumers in the datapath test SoC.

## Interface
- `WIDTH`, default 4, operand and result width in bits (≥1).
- `N_IN`, default 4, operands per beat (≥2).
- `CNT_W`, default 8, width of the beat counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: input beat accepted when `in_valid && in_ready`.
- `in_data` input `N_IN*WIDTH`: packed operands; operand k is `in_data[k*WIDTH +: WIDTH]`.
- `in_op` input 2: 0 AND, 1 OR, 2 XOR, 3 NAND; sampled on the first beat of a packet only.
- `in_last` input 1: final beat of the packet.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready`.
- `out_data` output `WIDTH`: packet result.
- `out_count` output `CNT_W`: number of beats in the packet.
- `out_parity` output 1: present only with `LOGIC_REDUCE_PARITY_EN`.

## Operation
- Clock is `clk`; reset is synchronous and active-high, on port `rst`.
- Beat reduction is combinational: all `N_IN` operands are combined with the base op (AND for both AND and NAND).
- The packet fold combines the running accumulator with the beat result using the same base op.
- NAND inverts only the final packet result; intermediate folds do not invert.
- State machine:
  - IDLE: no packet open.
  - ACCUM: accumulator holds at least one non-last beat.
  - HOLD: `out_valid`=1.
- Transitions:
  - IDLE → ACCUM on an accepted non-last beat. The op is latched, acc = beat result, cnt = 1.
  - IDLE → HOLD on an accepted last beat. The op is latched, result = beat result with NAND inversion applied, cnt = 1.
  - ACCUM → ACCUM on an accepted non-last beat: fold, cnt+1.
  - ACCUM → HOLD on an accepted last beat: fold, cnt+1, result registered.
  - HOLD → IDLE on `out_ready` with no accepted beat.
  - HOLD → ACCUM or HOLD when `out_ready` and an accepted beat occur in the same cycle. The new packet starts, with the same rules as from IDLE.
- `in_ready` = (state != HOLD) || `out_ready`. It is combinational and therefore 1 in IDLE and ACCUM.
- `out_count` saturates at 2^CNT_W−1; the fold continues past saturation.
- `in_op` changes mid-packet are ignored.
- `out_data` and `out_count` remain stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `out_count`=0, accumulator 0, `out_parity`=0, `in_ready`=1.
- Latency: the accepted last beat at edge n gives `out_valid`=1 after edge n, i.e. one cycle.
- Throughput: one beat per cycle, including back-to-back single-beat packets while `out_ready` is held 1.
- Reset asserted mid-packet or during HOLD discards the accumulator and any pending result. The next cycle matches the reset values.
- `rst` has priority over every handshake in the same cycle.

## Configuration
- `LOGIC_REDUCE_PARITY_EN` defined: adds the `out_parity` port, registered alongside `out_data` as the XOR of all `out_data` bits (even parity).
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `logic_reduce_pkg` contains:
  - `op_e` (OP_AND=0, OP_OR=1, OP_XOR=2, OP_NAND=3);
  - `state_e` (IDLE, ACCUM, HOLD);
  - function `base_op(op_e, a, b)`.
- Sub-module `reduce_tree`: combinational `N_IN`-operand reduction, parameters `WIDTH` and `N_IN`, input op, output beat result.
- `logic_reduce_unit` holds the FSM, accumulator, counter and output register.

## Test plan
All scenarios use `WIDTH`=4, `N_IN`=4.
- Single-beat AND, last=1, operands 0001/0000/1111/1101 → next cycle `out_valid`=1, `out_data`=0000, `out_count`=1.
- Two-beat OR: beat1 0001/0000/0000/0000, beat2 last 0000/0100/0000/0000 → `out_data`=0101, `out_count`=2. Changing `in_op` to AND on beat2 has no effect.
- Single-beat NAND, operands 1111/1111/1010/1010 → `out_data`=0101. With the macro defined, `out_parity`=0.
- Backpressure: result pending with `out_ready`=0 for 3 cycles → `in_ready`=0, `out_data` stable. Raising `out_ready` together with a valid last XOR beat 0011/0101/1100/0110 gives the old result consumed and new `out_data`=1100 the next cycle.
- Reset mid-packet after 2 non-last beats, then a single last AND beat of all 1111 → `out_count`=1, `out_data`=1111.
- `CNT_W`=2, five-beat XOR packet → `out_count`=3 (saturated) and `out_data` = XOR of all 20 operands.
